// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU operations and datapath select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_JR     = 4'd12
  } state_e;

  // Which source the ALU decoder uses to pick the operation.
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_SUB = 2'd1,
    ALU_CLS_R   = 2'd2,
    ALU_CLS_I   = 2'd3
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // R-type funct codes that execute through EXEC_R (jr is handled separately).
  function automatic logic funct_is_alu(input logic [5:0] f);
    return (f == F_ADDU) || (f == F_SUBU) || (f == F_AND) || (f == F_OR) ||
           (f == F_XOR)  || (f == F_SLTU) || (f == F_SLL) || (f == F_SRL);
  endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// Combinational map from (state class, opcode, funct) to the ALU operation.
module alu_decoder
  import mips_pkg::*;
(
  input  alu_cls_e    cls_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alu_op_o
);

  // Select the operation; anything not decoded falls back to add.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (cls_i)
      ALU_CLS_SUB: alu_op_o = ALU_SUB;
      ALU_CLS_R: begin
        case (funct_i)
          F_ADDU:  alu_op_o = ALU_ADD;
          F_SUBU:  alu_op_o = ALU_SUB;
          F_AND:   alu_op_o = ALU_AND;
          F_OR:    alu_op_o = ALU_OR;
          F_XOR:   alu_op_o = ALU_XOR;
          F_SLTU:  alu_op_o = ALU_SLTU;
          F_SLL:   alu_op_o = ALU_SLL;
          F_SRL:   alu_op_o = ALU_SRL;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      ALU_CLS_I: begin
        case (opcode_i)
          OP_ANDI:  alu_op_o = ALU_AND;
          OP_ORI:   alu_op_o = ALU_OR;
          OP_SLTIU: alu_op_o = ALU_SLTU;
          OP_LUI:   alu_op_o = ALU_LUI;
          default:  alu_op_o = ALU_ADD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer. The state register is the only storage;
// every output is a combinational decode of state plus opcode/funct/aluZero.
//
// state  | meaning
// FETCH  | read instruction at PC into IR, PC <= PC+4
// DECODE | branch target into ALUOut, dispatch on opcode/funct
// MEMADR | compute load/store address
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to rt
// MEMWR  | write B register to memory at ALUOut
// EXEC_R | R-type ALU operation on A, B
// EXEC_I | immediate ALU operation on A, signImm
// ALUWB  | write ALUOut to rd (R-type) or rt (I-type)
// BRANCH | compare A, B; take branch from ALUOut
// JUMP   | PC <= jump target
// JAL    | PC <= jump target, $31 <= PC (already PC+4)
// JR     | PC <= A register
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       aluZero,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       iorD,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [3:0] aluOp,
  output logic [3:0] state,
  output logic       instrDone,
  output logic       illegal
);

  state_e   state_q, state_d;
  alu_cls_e alu_cls;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and output decode; reset forces FETCH selects with enables off.
  always_comb begin
    state_d   = S_FETCH;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    iorD      = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    regDst    = REGDST_RT;
    memToReg  = M2R_ALU;
    aluSrcA   = 1'b0;
    aluSrcB   = ALUB_B;
    pcSrc     = PCSRC_ALU;
    alu_cls   = ALU_CLS_ADD;
    instrDone = 1'b0;
    illegal   = 1'b0;
    if (rst) begin
      aluSrcB = ALUB_FOUR;
    end else begin
      case (state_q)
        S_FETCH: begin
          irWrite = 1'b1;
          aluSrcB = ALUB_FOUR;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          aluSrcB = ALUB_IMM_SH;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE: begin
              if (funct == F_JR)            state_d = S_JR;
              else if (funct_is_alu(funct)) state_d = S_EXEC_R;
              else begin
                illegal   = 1'b1;
                instrDone = 1'b1;
              end
            end
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_JAL:         state_d = S_JAL;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTIU, OP_LUI:
                            state_d = S_EXEC_I;
            default: begin
              illegal   = 1'b1;
              instrDone = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          aluSrcA = 1'b1;
          aluSrcB = ALUB_IMM;
          state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iorD    = 1'b1;
          state_d = S_MEMWB;
        end
        S_MEMWB: begin
          memToReg  = M2R_MEM;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_MEMWR: begin
          iorD      = 1'b1;
          memWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_EXEC_R: begin
          aluSrcA = 1'b1;
          alu_cls = ALU_CLS_R;
          state_d = S_ALUWB;
        end
        S_EXEC_I: begin
          aluSrcA = 1'b1;
          aluSrcB = ALUB_IMM;
          alu_cls = ALU_CLS_I;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          regDst    = (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA   = 1'b1;
          alu_cls   = ALU_CLS_SUB;
          pcSrc     = PCSRC_ALUOUT;
          pcWrite   = (opcode == OP_BNE) ? ~aluZero : aluZero;
          instrDone = 1'b1;
        end
        S_JUMP: begin
          pcSrc     = PCSRC_JUMP;
          pcWrite   = 1'b1;
          instrDone = 1'b1;
        end
        S_JAL: begin
          pcSrc     = PCSRC_JUMP;
          pcWrite   = 1'b1;
          regDst    = REGDST_RA;
          memToReg  = M2R_PC;
          regWrite  = 1'b1;
          instrDone = 1'b1;
        end
        S_JR: begin
          pcSrc     = PCSRC_REG;
          pcWrite   = 1'b1;
          instrDone = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .cls_i    (alu_cls),
    .opcode_i (opcode),
    .funct_i  (funct),
    .alu_op_o (aluOp)
  );

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for the multicycle MIPS controller.
module tb_multicycle_ctrl;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC_R = 4'd6;
  localparam logic [3:0] ST_EXEC_I = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JAL    = 4'd11;
  localparam logic [3:0] ST_JR     = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       aluZero;
  logic       irWrite, pcWrite, iorD, memWrite, regWrite;
  logic [1:0] regDst, memToReg, aluSrcB, pcSrc;
  logic       aluSrcA;
  logic [3:0] aluOp, state;
  logic       instrDone, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .aluZero(aluZero),
    .irWrite(irWrite), .pcWrite(pcWrite), .iorD(iorD), .memWrite(memWrite),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluOp(aluOp),
    .state(state), .instrDone(instrDone), .illegal(illegal)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Run until instrDone is seen (bounded); returns the cycle count of the instruction
  // counting the current FETCH cycle as cycle 1, then advances into the next FETCH.
  task automatic run_to_done(output int cyc);
    cyc = 1;
    while (instrDone !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b100011; funct = 6'b0; aluZero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== ST_FETCH) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected %0d", i, state, ST_FETCH); end
      checks++;
      if ({irWrite, pcWrite, regWrite, memWrite, instrDone, illegal} !== 6'b0) begin
        errors++; $display("FAIL reset_enables[%0d]: got %b expected 000000", i,
                           {irWrite, pcWrite, regWrite, memWrite, instrDone, illegal});
      end
    end
    checks++;
    if (aluSrcB !== 2'b01) begin errors++; $display("FAIL reset_aluSrcB: got %b expected 01", aluSrcB); end
    rst = 1'b0;
    #1;
    checks++;
    if ({irWrite, pcWrite} !== 2'b11) begin errors++; $display("FAIL reset_first_fetch: got %b expected 11", {irWrite, pcWrite}); end
  endtask

  task automatic test_lw();
    opcode = 6'b100011;
    checks++;
    if (regWrite !== 1'b0 || instrDone !== 1'b0) begin errors++; $display("FAIL lw_c1: got rw=%b done=%b expected 0 0", regWrite, instrDone); end
    step();
    checks++;
    if (state !== ST_DECODE || aluSrcB !== 2'b11) begin errors++; $display("FAIL lw_c2: got st=%0d srcB=%b expected 1 11", state, aluSrcB); end
    step();
    checks++;
    if (state !== ST_MEMADR || aluSrcA !== 1'b1 || aluSrcB !== 2'b10 || aluOp !== 4'b0101) begin
      errors++; $display("FAIL lw_c3: got st=%0d A=%b B=%b op=%b expected 2 1 10 0101", state, aluSrcA, aluSrcB, aluOp);
    end
    step();
    checks++;
    if (state !== ST_MEMRD || iorD !== 1'b1 || regWrite !== 1'b0 || instrDone !== 1'b0) begin
      errors++; $display("FAIL lw_c4: got st=%0d iorD=%b rw=%b done=%b expected 3 1 0 0", state, iorD, regWrite, instrDone);
    end
    step();
    checks++;
    if (state !== ST_MEMWB || regWrite !== 1'b1 || memToReg !== 2'b01 || regDst !== 2'b00 || instrDone !== 1'b1) begin
      errors++; $display("FAIL lw_c5: got st=%0d rw=%b m2r=%b dst=%b done=%b expected 4 1 01 00 1",
                         state, regWrite, memToReg, regDst, instrDone);
    end
    step();
    checks++;
    if (state !== ST_FETCH || instrDone !== 1'b0) begin errors++; $display("FAIL lw_next: got st=%0d done=%b expected 0 0", state, instrDone); end
  endtask

  task automatic test_sw();
    int cyc;
    opcode = 6'b101011;
    step(); step(); step();
    checks++;
    if (state !== ST_MEMWR || memWrite !== 1'b1 || iorD !== 1'b1 || regWrite !== 1'b0) begin
      errors++; $display("FAIL sw_c4: got st=%0d mw=%b iorD=%b rw=%b expected 5 1 1 0", state, memWrite, iorD, regWrite);
    end
    cyc = 4;
    if (instrDone === 1'b1) step();
    else begin cyc = 0; step(); end
    checks++;
    if (cyc !== 4 || state !== ST_FETCH) begin errors++; $display("FAIL sw_cycles: got %0d st=%0d expected 4 0", cyc, state); end
  endtask

  task automatic test_rtype_sub();
    int cyc;
    opcode = 6'b000000; funct = 6'b100011;
    step(); step();
    checks++;
    if (state !== ST_EXEC_R || aluOp !== 4'b0110 || aluSrcA !== 1'b1 || aluSrcB !== 2'b00) begin
      errors++; $display("FAIL rsub_exec: got st=%0d op=%b A=%b B=%b expected 6 0110 1 00", state, aluOp, aluSrcA, aluSrcB);
    end
    step();
    checks++;
    if (state !== ST_ALUWB || regDst !== 2'b01 || regWrite !== 1'b1 || memToReg !== 2'b00) begin
      errors++; $display("FAIL rsub_wb: got st=%0d dst=%b rw=%b m2r=%b expected 8 01 1 00", state, regDst, regWrite, memToReg);
    end
    step();
    // Re-run a second R-type (sll) and count its length.
    funct = 6'b000000;
    step(); step();
    checks++;
    if (aluOp !== 4'b1010) begin errors++; $display("FAIL rsll_op: got %b expected 1010", aluOp); end
    step();
    cyc = (instrDone === 1'b1) ? 4 : 0;
    step();
    checks++;
    if (cyc !== 4 || state !== ST_FETCH) begin errors++; $display("FAIL rtype_cycles: got %0d st=%0d expected 4 0", cyc, state); end
  endtask

  task automatic test_itype_lui();
    opcode = 6'b001111;
    step(); step();
    checks++;
    if (state !== ST_EXEC_I || aluOp !== 4'b1100 || aluSrcB !== 2'b10) begin
      errors++; $display("FAIL lui_exec: got st=%0d op=%b B=%b expected 7 1100 10", state, aluOp, aluSrcB);
    end
    step();
    checks++;
    if (state !== ST_ALUWB || regDst !== 2'b00 || regWrite !== 1'b1 || instrDone !== 1'b1) begin
      errors++; $display("FAIL lui_wb: got st=%0d dst=%b rw=%b done=%b expected 8 00 1 1", state, regDst, regWrite, instrDone);
    end
    step();
  endtask

  task automatic test_branches();
    int cyc;
    // beq taken
    opcode = 6'b000100; aluZero = 1'b1;
    step(); step();
    checks++;
    if (state !== ST_BRANCH || pcWrite !== 1'b1 || pcSrc !== 2'b01 || aluOp !== 4'b0110 || instrDone !== 1'b1) begin
      errors++; $display("FAIL beq_taken: got st=%0d pcw=%b src=%b op=%b done=%b expected 9 1 01 0110 1",
                         state, pcWrite, pcSrc, aluOp, instrDone);
    end
    step();
    checks++;
    if (state !== ST_FETCH) begin errors++; $display("FAIL beq_cycles: got st=%0d expected 0", state); end
    // bne not taken (equal operands)
    opcode = 6'b000101; aluZero = 1'b1;
    run_to_done(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL bne_cycles: got %0d expected 3", cyc); end
    step(); step();
    checks++;
    if (state !== ST_BRANCH || pcWrite !== 1'b0) begin errors++; $display("FAIL bne_equal: got st=%0d pcw=%b expected 9 0", state, pcWrite); end
    aluZero = 1'b0;
    #1;
    checks++;
    if (pcWrite !== 1'b1) begin errors++; $display("FAIL bne_taken: got pcw=%b expected 1", pcWrite); end
    step();
    aluZero = 1'b0;
  endtask

  task automatic test_jal_jr();
    int cyc;
    opcode = 6'b000011;
    step(); step();
    checks++;
    if (state !== ST_JAL || pcWrite !== 1'b1 || pcSrc !== 2'b10 || regDst !== 2'b10 ||
        memToReg !== 2'b10 || regWrite !== 1'b1 || instrDone !== 1'b1) begin
      errors++; $display("FAIL jal_c3: got st=%0d pcw=%b src=%b dst=%b m2r=%b rw=%b done=%b expected 11 1 10 10 10 1 1",
                         state, pcWrite, pcSrc, regDst, memToReg, regWrite, instrDone);
    end
    step();
    opcode = 6'b000000; funct = 6'b001000;
    step(); step();
    checks++;
    if (state !== ST_JR || pcSrc !== 2'b11 || pcWrite !== 1'b1 || regWrite !== 1'b0) begin
      errors++; $display("FAIL jr_c3: got st=%0d src=%b pcw=%b rw=%b expected 12 11 1 0", state, pcSrc, pcWrite, regWrite);
    end
    step();
    opcode = 6'b000010;
    run_to_done(cyc);
    checks++;
    if (cyc !== 3 || state !== ST_FETCH) begin errors++; $display("FAIL j_cycles: got %0d st=%0d expected 3 0", cyc, state); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    step();
    checks++;
    if (state !== ST_DECODE || illegal !== 1'b1 || instrDone !== 1'b1) begin
      errors++; $display("FAIL illegal_op: got st=%0d ill=%b done=%b expected 1 1 1", state, illegal, instrDone);
    end
    step();
    checks++;
    if (state !== ST_FETCH || illegal !== 1'b0) begin errors++; $display("FAIL illegal_next: got st=%0d ill=%b expected 0 0", state, illegal); end
    opcode = 6'b000000; funct = 6'b111111;
    step();
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_funct: got %b expected 1", illegal); end
    step();
  endtask

  task automatic test_mid_reset();
    opcode = 6'b100011;
    step(); step(); step();
    checks++;
    if (state !== ST_MEMRD) begin errors++; $display("FAIL midrst_pre: got st=%0d expected 3", state); end
    rst = 1'b1;
    #1;
    checks++;
    if ({irWrite, pcWrite, regWrite, memWrite, instrDone, illegal} !== 6'b0 || aluSrcB !== 2'b01 || iorD !== 1'b0) begin
      errors++; $display("FAIL midrst_cycle: got en=%b B=%b iorD=%b expected 000000 01 0",
                         {irWrite, pcWrite, regWrite, memWrite, instrDone, illegal}, aluSrcB, iorD);
    end
    step();
    checks++;
    if (state !== ST_FETCH || regWrite !== 1'b0) begin errors++; $display("FAIL midrst_next: got st=%0d rw=%b expected 0 0", state, regWrite); end
    rst = 1'b0;
    #1;
    checks++;
    if (irWrite !== 1'b1 || regWrite !== 1'b0) begin errors++; $display("FAIL midrst_refetch: got ir=%b rw=%b expected 1 0", irWrite, regWrite); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_itype_lui();
    test_branches();
    test_jal_jr();
    test_illegal();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state control sequencer that turns the team's single-cycle MIPS datapath into a multicycle datapath with a shared instruction/data memory, instruction register and A/B/ALUOut holding registers. It decodes `opcode`/`funct` once per instruction and steps through fetch, decode, execute, memory and write-back states. It drives every enable and mux select, so that one ALU and one memory port serve all phases. It sits beside the datapath and replaces the combinational control `always` block.

## Interface
- Parameters: none. State and ALU-operation encodings come from the shared package.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  `instr[31:26]` from the instruction register
- `funct`  in  6  `instr[5:0]` from the instruction register
- `aluZero`  in  1  ALU zero flag
- `irWrite`  out  1  load instruction register
- `pcWrite`  out  1  PC load enable; includes the resolved branch condition
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memWrite`  out  1  memory write strobe
- `regWrite`  out  1  register-file write enable
- `regDst`  out  2  destination select: 00 = rt, 01 = rd, 10 = $31
- `memToReg`  out  2  write-back select: 00 = ALUOut, 01 = memory data register, 10 = PC
- `aluSrcA`  out  1  ALU A input: 0 = PC, 1 = A register
- `aluSrcB`  out  2  ALU B input: 00 = B register, 01 = constant 4, 10 = signImm, 11 = signImm<<2
- `pcSrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A register
- `aluOp`  out  4  ALU operation: 0101 add, 0110 sub, 0001 and, 0011 or, 0010 xor, 1000 sltu, 1010 sll, 1011 srl, 1100 lui
- `state`  out  4  current state, for debug
- `instrDone`  out  1  one-cycle pulse in the last cycle of each instruction
- `illegal`  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported

## Operation
- The state register is the only storage. All outputs are combinational decodes of the state, plus `opcode`/`funct`/`aluZero` where noted.
- Unlisted outputs are 0 in every state. `aluOp` defaults to 0101 (add).
- **FETCH:** `iorD`=0, `irWrite`=1, `aluSrcA`=0, `aluSrcB`=01, `pcSrc`=00, `pcWrite`=1. Next state is DECODE.
- **DECODE:** `aluSrcA`=0, `aluSrcB`=11, add (computes the branch target into ALUOut). Next state by opcode:
  - 100011 / 101011 → MEMADR
  - 000000 with funct 001000 → JR
  - 000000 with another supported funct → EXEC_R
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000 / 001001 / 001100 / 001101 / 001011 / 001111 → EXEC_I
  - anything else → FETCH, with `illegal`=1 and `instrDone`=1
- **MEMADR:** `aluSrcA`=1, `aluSrcB`=10, add. Next state is MEMRD for lw, MEMWR for sw.
- **MEMRD:** `iorD`=1. Next state is MEMWB.
- **MEMWB:** `regDst`=00, `memToReg`=01, `regWrite`=1, `instrDone`=1. Next state is FETCH.
- **MEMWR:** `iorD`=1, `memWrite`=1, `instrDone`=1. Next state is FETCH.
- **EXEC_R:** `aluSrcA`=1, `aluSrcB`=00, `aluOp` from funct:
  - 100001 → 0101
  - 100011 → 0110
  - 100100 → 0001
  - 100101 → 0011
  - 100110 → 0010
  - 101011 → 1000
  - 000000 → 1010
  - 000010 → 1011
  - Next state is ALUWB.
- **EXEC_I:** `aluSrcA`=1, `aluSrcB`=10, `aluOp` from opcode (addi/addiu → 0101, andi → 0001, ori → 0011, sltiu → 1000, lui → 1100). Next state is ALUWB.
- **ALUWB:** `regDst`=01 for R-type and 00 for I-type (from the latched opcode), `memToReg`=00, `regWrite`=1, `instrDone`=1. Next state is FETCH.
- **BRANCH:**
  - `aluSrcA`=1, `aluSrcB`=00, sub, `pcSrc`=01.
  - `pcWrite` = (`aluZero` == 1) for beq; `pcWrite` = (`aluZero` == 0) for bne.
  - `instrDone`=1. Next state is FETCH.
- **JUMP:** `pcSrc`=10, `pcWrite`=1, `instrDone`=1. Next state is FETCH.
- **JAL:** `pcSrc`=10, `pcWrite`=1, `regDst`=10, `memToReg`=10, `regWrite`=1, `instrDone`=1. The written value is the PC already advanced to PC+4. Next state is FETCH.
- **JR:** `pcSrc`=11, `pcWrite`=1, `instrDone`=1. Next state is FETCH.

## Timing
- Cycles per instruction:
  - lw: 5
  - sw, R-type, I-type ALU: 4
  - beq, bne, j, jal, jr: 3
  - illegal: 2
- `instrDone` is high exactly in the final cycle of each instruction.
- **Reset:**
  - While `rst` is high, every enable (`irWrite`, `pcWrite`, `memWrite`, `regWrite`) and every pulse output (`instrDone`, `illegal`) is forced to 0. Selects hold their FETCH values.
  - On the first edge with `rst` sampled high, `state` = FETCH.
  - The first fetch happens in the first cycle after `rst` deasserts.
- Asserting `rst` mid-instruction abandons the instruction. No enable fires in the reset cycle.
- `opcode` and `funct` are sampled only in DECODE and later states; their value during FETCH is ignored.
- Unreachable state encodings go to FETCH on the next edge with all enables 0.

## Structure
- Package `mips_pkg` holds:
  - the state enum (4-bit)
  - opcode and funct localparams
  - ALU-operation constants
  - the `aluSrcB`, `pcSrc`, `regDst` and `memToReg` select encodings
- One sub-module, `alu_decoder`: a combinational map from (state class, opcode, funct) to `aluOp`. The FSM itself stays in `multicycle_ctrl`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with opcode=100011 → `state`=FETCH; `irWrite`, `pcWrite`, `regWrite` and `memWrite` stay 0. On the first cycle after release, `irWrite`=1 and `pcWrite`=1.
- **lw:** opcode=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regWrite`=1 with `memToReg`=01 in cycle 5 only; `instrDone` pulses in cycle 5.
- **R-type sub:** opcode=000000, funct=100011 → `aluOp`=0110 in EXEC_R; ALUWB has `regDst`=01 and `regWrite`=1; 4 cycles total.
- **Branches:**
  - beq with `aluZero`=1 in BRANCH → `pcWrite`=1, `pcSrc`=01.
  - bne with `aluZero`=1 → `pcWrite`=0.
  - Both take 3 cycles.
- **jal:** opcode=000011 → cycle 3 has `pcWrite`=1, `pcSrc`=10, `regDst`=10, `memToReg`=10, `regWrite`=1.
- **Illegal opcode and mid-instruction reset:**
  - opcode=111111 → `illegal`=1 and `instrDone`=1 in DECODE, then FETCH.
  - `rst` asserted in MEMRD → next state is FETCH and `regWrite` is never asserted for that lw.
